add_bist_checker: RTL
=====================

Name: add_bist_checker

Overview:
- Self-test engine at the opposite end of the adder operand/result interface: it drives operands a and b and consumes result y.
- It sweeps all 2^(2*WIDTH) operand pairs exhaustively.
- For each pair it computes the expected sum internally and compares it with the sampled y.
- It counts mismatches and logs the first failing vector. It sits beside the adder instance, wired to the same operand/result signals.

Parameters:
- WIDTH, 4, operand width; the result is WIDTH+1 bits.
- SETTLE, 1, cycles operands are held before y is sampled (>=1).

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- start  input  1  single-cycle pulse that begins a sweep.
- a  output  WIDTH  operand a to the adder.
- b  output  WIDTH  operand b to the adder.
- y  input  WIDTH+1  adder result.
- busy  output  1  high while a sweep is running.
- done  output  1  high from sweep end until the next accepted start.
- pass  output  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  output  2*WIDTH+1  count of mismatching vectors.
- fail_a  output  WIDTH  a operand of the first failure.
- fail_b  output  WIDTH  b operand of the first failure.
- fail_y  output  WIDTH+1  y captured at the first failure.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE.
  - Vector counter cnt (2*WIDTH bits), settle counter, and all outputs are cleared to 0.
  - Reset mid-sweep aborts the sweep immediately; no partial results are kept.
- Operand mapping: a = cnt[2*WIDTH-1:WIDTH], b = cnt[WIDTH-1:0], both taken directly from registers (glitch-free).
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1: clear cnt, err_cnt and fail_*; set busy=1, done=0, pass=0; go to SETTLE.
- SETTLE:
  - Hold a and b for SETTLE cycles, then go to CHECK.
- CHECK (one cycle):
  - Expected value = zero-extended a + zero-extended b, computed at WIDTH+1 bits; no carry is lost.
  - On mismatch, err_cnt increments; it is wide enough to hold 2^(2*WIDTH) and never saturates.
  - On a mismatch with err_cnt==0, capture a, b and y into fail_a, fail_b and fail_y. Later failures do not overwrite them.
  - If cnt is all-ones: go to DONE, set busy=0, done=1, and pass = (final err_cnt==0), which includes this cycle's compare.
  - Otherwise cnt increments and the FSM returns to SETTLE.
- Cycle counts:
  - Per-vector cost is SETTLE+1 cycles.
  - Sweep length is 2^(2*WIDTH)*(SETTLE+1) cycles. Defaults give 512 cycles from the start edge to done=1.
- Start handling:
  - start while busy=1 is ignored.
  - start in DONE behaves as in IDLE and clears results on the same edge that sets busy.
- Output lifetime:
  - fail_* stay 0 when no failure has occurred.
  - err_cnt, pass and fail_* hold their values in DONE until the next start or reset.
- cnt does not wrap within a sweep; termination occurs at all-ones before any increment.

Optional Feature:
- Macro ABORT_ON_ERR_EN.
- When defined, the first mismatch in CHECK ends the sweep on that edge: go to DONE, busy=0, done=1, pass=0, err_cnt=1, fail_* captured.
- When undefined, the full sweep always runs and every mismatch is counted.

Decomposition:
- Package add_bist_pkg holds:
  - the FSM state enum (IDLE, SETTLE, CHECK, DONE);
  - the default WIDTH and SETTLE constants;
  - a function computing the expected sum at WIDTH+1 bits.
- Single module; no sub-module is warranted. The counter and comparator are a few lines each.

Test Plan:
- Connected to a correct 4-bit adder, start pulse:
  - busy=1 for 512 cycles, then done=1, pass=1, err_cnt=0, fail_a/b/y=0.
- y[0] forced to 0:
  - err_cnt=128 (all odd sums), pass=0.
  - First failure fail_a=0, fail_b=1, fail_y=0.
- y[4] forced to 0:
  - err_cnt=120 (sums >=16), pass=0.
  - First failure fail_a=1, fail_b=15, fail_y=0.
- Extra start pulses at cycles 10 and 300 of a sweep:
  - Ignored; done still arrives 512 cycles after the first start with the same results.
- rst_n=0 for one cycle at cycle 200 of a sweep:
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - A new start completes a full 512-cycle sweep.
- ABORT_ON_ERR_EN defined, y[0] forced to 0:
  - done=1 four cycles after start (second vector).
  - err_cnt=1, pass=0, fail_a=0, fail_b=1, fail_y=0.

Source files
------------

// File: rtl/add_bist_pkg.sv
// Shared types and helpers for the adder BIST checker: FSM state encoding,
// default geometry, and the reference sum used by the comparator.
package add_bist_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int SETTLE_DEF = 1;
  localparam int SUM_MAX_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  // Operands are zero-extended by one bit so the carry out is kept.
  function automatic logic [SUM_MAX_W:0] expected_sum(input logic [SUM_MAX_W-1:0] a,
                                                       input logic [SUM_MAX_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/add_bist_checker_if.sv
// Operand/result bus between the BIST checker and the adder under test,
// together with the checker's control and result signals.
interface add_bist_checker_if
  import add_bist_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH:0]     y;
  logic               busy;
  logic               done;
  logic               pass;
  logic [2*WIDTH:0]   err_cnt;
  logic [WIDTH-1:0]   fail_a;
  logic [WIDTH-1:0]   fail_b;
  logic [WIDTH:0]     fail_y;

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_cnt, fail_a, fail_b, fail_y
  );

  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_cnt, fail_a, fail_b, fail_y
  );

endinterface

// File: rtl/add_bist_checker.sv
// Exhaustive self-test engine for a WIDTH-bit adder: sweeps every operand pair,
// counts mismatches and records the first failing vector. Option: ABORT_ON_ERR_EN.
module add_bist_checker
  import add_bist_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  add_bist_checker_if.master  bus
);

  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] cnt_q, cnt_d;
  logic [SCW-1:0]     settle_q, settle_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [2*WIDTH:0]   err_q, err_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d;
  logic [WIDTH-1:0]   fail_b_q, fail_b_d;
  logic [WIDTH:0]     fail_y_q, fail_y_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH:0]     exp_sum;
  logic               mismatch;
  logic               finish;

  assign op_a     = cnt_q[2*WIDTH-1:WIDTH];
  assign op_b     = cnt_q[WIDTH-1:0];
  assign exp_sum  = (WIDTH+1)'(expected_sum(SUM_MAX_W'(op_a), SUM_MAX_W'(op_b)));
  assign mismatch = (bus.y != exp_sum);

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    fail_y_d = fail_y_q;
    finish   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          cnt_d    = '0;
          settle_d = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          fail_y_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SCW'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_a_d = op_a;
            fail_b_d = op_b;
            fail_y_d = bus.y;
          end
        end
`ifdef ABORT_ON_ERR_EN
        finish = (&cnt_q) | mismatch;
`else
        finish = &cnt_q;
`endif
        if (finish) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset clears everything, so an aborted sweep leaves no partial results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      fail_y_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      fail_y_q <= fail_y_d;
    end
  end

  assign bus.a       = op_a;
  assign bus.b       = op_b;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_q;
  assign bus.fail_a  = fail_a_q;
  assign bus.fail_b  = fail_b_q;
  assign bus.fail_y  = fail_y_q;

endmodule
